// File: rtl/hist_eq_sequencer.sv
// Phase sequencer for the histogram-equalization filter datapath: turns button edges
// into LOAD / CLR / HIST / CDF / MAP phases and drives buffer and table strobes.
module hist_eq_sequencer #(
    parameter int NUM_PIXELS = 16,
    parameter int ADDR_W     = 4,
    parameter int LEVELS     = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              readButton,
    input  logic              applyFilterButton,
    input  logic [1:0]        filterType,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              load_en,
    output logic              pix_rd_en,
    output logic [7:0]        bin_addr,
    output logic              hist_clr,
    output logic              hist_inc,
    output logic              cdf_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        mode,
    output logic [2:0]        stage,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Counter must reach NUM_PIXELS (HIST/MAP tail cycle) and LEVELS-1.
    localparam int CNT_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0] PIX_END  = CNT_W'(NUM_PIXELS);
    localparam logic [CNT_W-1:0] BIN_LAST = CNT_W'(LEVELS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CLR  = 3'd2,
        S_HIST = 3'd3,
        S_CDF  = 3'd4,
        S_MAP  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              read_prev_q, apply_prev_q;
    logic              loaded_q, loaded_d;
    logic [1:0]        mode_q, mode_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hist_inc_q, wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              read_edge, apply_edge;

    assign read_edge  = readButton & ~read_prev_q;
    assign apply_edge = applyFilterButton & ~apply_prev_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        loaded_d  = loaded_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        load_en   = 1'b0;
        pix_rd_en = 1'b0;
        hist_clr  = 1'b0;
        cdf_en    = 1'b0;
        pix_addr  = '0;
        bin_addr  = '0;

        unique case (state_q)
            S_IDLE: begin
                // Read has priority; a simultaneous apply edge is dropped.
                if (read_edge) begin
                    state_d = S_LOAD;
                end else if (apply_edge) begin
                    if (!loaded_q || filterType == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = filterType;
                        state_d = (filterType == 2'b00) ? S_CLR : S_MAP;
                    end
                end
            end
            S_LOAD: begin
                load_en  = 1'b1;
                pix_addr = cnt_q[ADDR_W-1:0];
                if (cnt_q == PIX_LAST) begin
                    state_d  = S_IDLE;
                    loaded_d = 1'b1;
                    done_d   = 1'b1;
                end
            end
            S_CLR: begin
                hist_clr = 1'b1;
                bin_addr = cnt_q[7:0];
                if (cnt_q == BIN_LAST) state_d = S_HIST;
            end
            S_HIST: begin
                if (cnt_q < PIX_END) begin
                    pix_rd_en = 1'b1;
                    pix_addr  = cnt_q[ADDR_W-1:0];
                end
                if (cnt_q == PIX_END) state_d = S_CDF;
            end
            S_CDF: begin
                cdf_en   = 1'b1;
                bin_addr = cnt_q[7:0];
                if (cnt_q == BIN_LAST) state_d = S_MAP;
            end
            S_MAP: begin
                if (cnt_q < PIX_END) begin
                    pix_rd_en = 1'b1;
                    pix_addr  = cnt_q[ADDR_W-1:0];
                end
                if (cnt_q == PIX_END) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Zeroed on every state entry; terminal counts force a transition, so no wrap.
        if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
        else                                         cnt_d = cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            read_prev_q  <= 1'b0;
            apply_prev_q <= 1'b0;
            loaded_q     <= 1'b0;
            mode_q       <= 2'b00;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            hist_inc_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            read_prev_q  <= readButton;
            apply_prev_q <= applyFilterButton;
            loaded_q     <= loaded_d;
            mode_q       <= mode_d;
            done_q       <= done_d;
            err_q        <= err_d;
            hist_inc_q   <= pix_rd_en & (state_q == S_HIST);
            wr_en_q      <= pix_rd_en & (state_q == S_MAP);
            wr_addr_q    <= pix_addr;
        end
    end

    assign hist_inc = hist_inc_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign mode     = mode_q;
    assign stage    = state_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_hist_eq_sequencer.sv
// Directed bench for hist_eq_sequencer: reset, load, equalize, negative/threshold,
// request rejection, busy-time edge discard and asynchronous reset mid-run.
module tb_hist_eq_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       readButton = 1'b0;
    logic       applyFilterButton = 1'b0;
    logic [1:0] filterType = 2'b00;
    logic [3:0] pix_addr, wr_addr;
    logic       load_en, pix_rd_en, hist_clr, hist_inc, cdf_en, wr_en;
    logic [7:0] bin_addr;
    logic [1:0] mode;
    logic [2:0] stage;
    logic       busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    hist_eq_sequencer #(.NUM_PIXELS(16), .ADDR_W(4), .LEVELS(256)) dut (
        .clock(clock), .reset(reset),
        .readButton(readButton), .applyFilterButton(applyFilterButton),
        .filterType(filterType),
        .pix_addr(pix_addr), .load_en(load_en), .pix_rd_en(pix_rd_en),
        .bin_addr(bin_addr), .hist_clr(hist_clr), .hist_inc(hist_inc),
        .cdf_en(cdf_en), .wr_en(wr_en), .wr_addr(wr_addr), .mode(mode),
        .stage(stage), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Steps through one run started by a button already raised by the caller,
    // collecting strobe counts and per-cycle ordering violations.
    task automatic measure(input int poke_at, input int ft_change_at, input logic [1:0] ft_new,
                           output int busy_n, output int clr_n, output int inc_n,
                           output int cdf_n, output int rd_n, output int wr_n,
                           output int done_n, output int err_n, output int seq_bad,
                           output logic [2:0] first_stage, output logic [1:0] first_mode,
                           output logic done_end, output logic timeout);
        bit   started = 0;
        bit   finished = 0;
        int   phase_rd = 0;
        logic [2:0] last_stage = 3'd0;
        logic prev_rd_hist = 1'b0;
        logic prev_rd_map = 1'b0;
        busy_n = 0; clr_n = 0; inc_n = 0; cdf_n = 0; rd_n = 0; wr_n = 0;
        done_n = 0; err_n = 0; seq_bad = 0;
        first_stage = 3'd0; first_mode = 2'b00; done_end = 1'b0; timeout = 1'b0;
        for (int cyc = 0; cyc < 1200 && !finished; cyc++) begin
            step();
            if (cyc == 0) begin
                readButton = 1'b0;
                applyFilterButton = 1'b0;
            end
            if (busy) begin
                if (!started) begin
                    first_stage = stage;
                    first_mode  = mode;
                    started     = 1;
                end
                busy_n++;
                if (busy_n == poke_at) begin
                    readButton = 1'b1;
                    applyFilterButton = 1'b1;
                end
                if (busy_n == poke_at + 3) begin
                    readButton = 1'b0;
                    applyFilterButton = 1'b0;
                end
                if (busy_n == ft_change_at) filterType = ft_new;
            end
            if (stage != last_stage) phase_rd = 0;
            if (hist_inc !== prev_rd_hist) seq_bad++;
            if (wr_en !== prev_rd_map) seq_bad++;
            if (hist_clr && bin_addr != clr_n[7:0]) seq_bad++;
            if (cdf_en && bin_addr != cdf_n[7:0]) seq_bad++;
            if (pix_rd_en) begin
                if (pix_addr != phase_rd[3:0]) seq_bad++;
                phase_rd++;
            end
            if (wr_en && wr_addr != wr_n[3:0]) seq_bad++;
            if (!load_en && !pix_rd_en && pix_addr != 4'd0) seq_bad++;
            if (!hist_clr && !cdf_en && bin_addr != 8'd0) seq_bad++;
            if (started && mode != first_mode) seq_bad++;
            clr_n += int'(hist_clr);
            inc_n += int'(hist_inc);
            cdf_n += int'(cdf_en);
            rd_n  += int'(pix_rd_en);
            wr_n  += int'(wr_en);
            done_n += int'(done);
            err_n  += int'(err);
            prev_rd_hist = pix_rd_en && stage == 3'd3;
            prev_rd_map  = pix_rd_en && stage == 3'd5;
            last_stage   = stage;
            if (started && !busy) begin
                done_end = done;
                for (int k = 0; k < 3; k++) begin
                    step();
                    done_n += int'(done);
                    err_n  += int'(err);
                    if (busy) seq_bad++;
                end
                finished = 1;
            end
            if (!started && cyc >= 3) finished = 1;
        end
        if (!finished) timeout = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({busy, stage, load_en, pix_rd_en, hist_clr, hist_inc, cdf_en, wr_en, done, err} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {busy, stage, load_en, pix_rd_en, hist_clr, hist_inc, cdf_en, wr_en, done, err});
        end
        n_checks++;
        if ({pix_addr, bin_addr, wr_addr, mode} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h expected 0", {pix_addr, bin_addr, wr_addr, mode});
        end
        step();
        reset = 1'b1;
        step();
        n_checks++;
        if (stage !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got stage=%0d busy=%0d expected 0 0", stage, busy);
        end
    endtask

    task automatic test_apply_before_load();
        int strobes = 0;
        int errs = 0;
        filterType = 2'b00;
        applyFilterButton = 1'b1;
        step();
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL unloaded_apply_err: got err=%0d busy=%0d expected 1 0", err, busy);
        end
        applyFilterButton = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            errs += int'(err);
            strobes += int'(load_en | pix_rd_en | hist_clr | hist_inc | cdf_en | wr_en | busy);
        end
        n_checks++;
        if (errs != 0 || strobes != 0) begin
            n_fail++;
            $display("FAIL unloaded_apply_quiet: got err_cycles=%0d strobe_cycles=%0d expected 0 0", errs, strobes);
        end
    endtask

    task automatic test_load();
        int bad = 0;
        readButton = 1'b1;
        step();
        readButton = 1'b0;
        n_checks++;
        if (stage !== 3'd1 || load_en !== 1'b1 || pix_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL load_first_cycle: got stage=%0d load_en=%0d pix_addr=%0d expected 1 1 0",
                     stage, load_en, pix_addr);
        end
        for (int i = 1; i < 16; i++) begin
            step();
            if (load_en !== 1'b1 || pix_addr !== 4'(i) || busy !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL load_sequence: got %0d bad cycles expected 0", bad);
        end
        step();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || stage !== 3'd0 || load_en !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: got done=%0d busy=%0d stage=%0d load_en=%0d expected 1 0 0 0",
                     done, busy, stage, load_en);
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done_pulse: got done=%0d expected 0", done);
        end
    endtask

    task automatic run_equalize(input int poke_at, input string tag);
        int busy_n, clr_n, inc_n, cdf_n, rd_n, wr_n, done_n, err_n, seq_bad;
        logic [2:0] fs;
        logic [1:0] fm;
        logic de, to;
        filterType = 2'b00;
        applyFilterButton = 1'b1;
        measure(poke_at, 0, 2'b00, busy_n, clr_n, inc_n, cdf_n, rd_n, wr_n, done_n, err_n,
                seq_bad, fs, fm, de, to);
        n_checks++;
        if (to !== 1'b0 || busy_n != 546) begin
            n_fail++;
            $display("FAIL %s_busy_len: got %0d timeout=%0d expected 546 0", tag, busy_n, to);
        end
        n_checks++;
        if (fs !== 3'd2 || fm !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_first_stage: got stage=%0d mode=%0d expected 2 0", tag, fs, fm);
        end
        n_checks++;
        if (clr_n != 256 || inc_n != 16 || cdf_n != 256 || rd_n != 32 || wr_n != 16) begin
            n_fail++;
            $display("FAIL %s_strobe_counts: got clr=%0d inc=%0d cdf=%0d rd=%0d wr=%0d expected 256 16 256 32 16",
                     tag, clr_n, inc_n, cdf_n, rd_n, wr_n);
        end
        n_checks++;
        if (de !== 1'b1 || done_n != 1 || err_n != 0) begin
            n_fail++;
            $display("FAIL %s_done: got done_end=%0d done_pulses=%0d err_pulses=%0d expected 1 1 0",
                     tag, de, done_n, err_n);
        end
        n_checks++;
        if (seq_bad != 0) begin
            n_fail++;
            $display("FAIL %s_ordering: got %0d violations expected 0", tag, seq_bad);
        end
    endtask

    task automatic run_short(input logic [1:0] ft, input int poke_at, input int ft_change_at,
                             input logic [1:0] ft_new, input string tag);
        int busy_n, clr_n, inc_n, cdf_n, rd_n, wr_n, done_n, err_n, seq_bad;
        logic [2:0] fs;
        logic [1:0] fm;
        logic de, to;
        filterType = ft;
        applyFilterButton = 1'b1;
        measure(poke_at, ft_change_at, ft_new, busy_n, clr_n, inc_n, cdf_n, rd_n, wr_n,
                done_n, err_n, seq_bad, fs, fm, de, to);
        n_checks++;
        if (to !== 1'b0 || busy_n != 17) begin
            n_fail++;
            $display("FAIL %s_busy_len: got %0d timeout=%0d expected 17 0", tag, busy_n, to);
        end
        n_checks++;
        if (fs !== 3'd5 || fm !== ft) begin
            n_fail++;
            $display("FAIL %s_start: got stage=%0d mode=%0d expected 5 %0d", tag, fs, fm, ft);
        end
        n_checks++;
        if (clr_n + inc_n + cdf_n != 0 || rd_n != 16 || wr_n != 16) begin
            n_fail++;
            $display("FAIL %s_strobes: got clr+inc+cdf=%0d rd=%0d wr=%0d expected 0 16 16",
                     tag, clr_n + inc_n + cdf_n, rd_n, wr_n);
        end
        n_checks++;
        if (de !== 1'b1 || done_n != 1 || err_n != 0 || seq_bad != 0) begin
            n_fail++;
            $display("FAIL %s_done_order: got done_end=%0d done=%0d err=%0d violations=%0d expected 1 1 0 0",
                     tag, de, done_n, err_n, seq_bad);
        end
    endtask

    task automatic test_equalize();
        run_equalize(0, "equalize");
    endtask

    task automatic test_negative();
        run_short(2'b01, 0, 5, 2'b10, "negative");
    endtask

    task automatic test_illegal_then_busy_edges();
        filterType = 2'b11;
        applyFilterButton = 1'b1;
        step();
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_err: got err=%0d busy=%0d expected 1 0", err, busy);
        end
        applyFilterButton = 1'b0;
        step();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_no_run: got err=%0d busy=%0d expected 0 0", err, busy);
        end
        run_short(2'b10, 4, 0, 2'b00, "threshold_poked");
        run_equalize(300, "equalize_poked");
    endtask

    task automatic test_reset_mid_run();
        bit found = 0;
        filterType = 2'b00;
        applyFilterButton = 1'b1;
        step();
        applyFilterButton = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (stage == 3'd3 && pix_addr == 4'd5) found = 1;
            else step();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_mid_reach_hist: got stage=%0d expected 3", stage);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, stage, pix_rd_en, hist_inc, hist_clr, cdf_en, wr_en, done, err, pix_addr, bin_addr} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%0d stage=%0d rd=%0d inc=%0d pix_addr=%0d expected all 0",
                     busy, stage, pix_rd_en, hist_inc, pix_addr);
        end
        #2;
        reset = 1'b1;
        step();
        applyFilterButton = 1'b1;
        step();
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_loaded_cleared: got err=%0d busy=%0d expected 1 0", err, busy);
        end
        applyFilterButton = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_apply_before_load();
        test_load();
        test_equalize();
        test_negative();
        test_illegal_then_busy_edges();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hist_eq_sequencer.md
# hist_eq_sequencer

Control FSM that sequences the `filter` datapath for intensity equalization of a buffered grayscale image. It turns the `readButton` and `applyFilterButton` presses into ordered phases: image load, histogram clear, histogram accumulation, CDF build and pixel remap. The phase taken depends on the 2-bit filter selection. It drives the image-buffer address, the histogram/CDF table strobes and the result-write strobe, and reports busy/done/error status to the top level.

## Interface
- `NUM_PIXELS`, 16: pixels per image; must be ≥ 2.
- `ADDR_W`, 4: pixel address width; 2^ADDR_W ≥ NUM_PIXELS.
- `LEVELS`, 256: histogram bins (8-bit intensity).
- `clock` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `readButton` in 1: level input; rising edge requests image load.
- `applyFilterButton` in 1: level input; rising edge requests filter run.
- `filterType` in 2: 00 equalize, 01 negative, 10 threshold, 11 illegal.
- `pix_addr` out ADDR_W: image-buffer address (load, read, write).
- `load_en` out 1: write the incoming pixel at `pix_addr`.
- `pix_rd_en` out 1: read the image buffer at `pix_addr`; data returns 1 cycle later.
- `bin_addr` out 8: histogram/CDF table index during CLR and CDF.
- `hist_clr` out 1: zero the bin at `bin_addr`.
- `hist_inc` out 1: increment the bin indexed by the returned pixel.
- `cdf_en` out 1: accumulate the CDF at `bin_addr`.
- `wr_en` out 1: write the mapped pixel to `wr_addr`.
- `wr_addr` out ADDR_W: `pix_addr` delayed 1 cycle.
- `mode` out 2: `filterType` latched at run start.
- `stage` out 3: IDLE=0, LOAD=1, CLR=2, HIST=3, CDF=4, MAP=5.
- `busy` out 1: high when the FSM is not in IDLE.
- `done` out 1: 1-cycle pulse when a load or run completes.
- `err` out 1: 1-cycle pulse when a request is rejected.

## Operation
- **Button edge detection.** Each button is sampled into a prev-register. An edge is `btn & ~prev`. Edges that arrive while `busy` are discarded, not queued.
- **IDLE + read edge → LOAD.**
  - Runs NUM_PIXELS cycles with `load_en`=1 and `pix_addr` = 0..NUM_PIXELS-1.
  - On exit: set the internal `loaded` flag, pulse `done`, return to IDLE.
- **IDLE + apply edge.**
  - If `loaded`=0 or `filterType`=11: pulse `err`, stay in IDLE.
  - Otherwise latch `mode`. Mode 00 goes to CLR; modes 01 and 10 go directly to MAP.
- **CLR.** LEVELS cycles, `hist_clr`=1, `bin_addr` = 0..255.
- **HIST.** NUM_PIXELS+1 cycles.
  - `pix_rd_en`=1 with `pix_addr` = 0..N-1 during the first N cycles.
  - `hist_inc` = `pix_rd_en` delayed 1 cycle (high in cycles 1..N).
- **CDF.** LEVELS cycles, `cdf_en`=1, `bin_addr` = 0..255.
- **MAP.** NUM_PIXELS+1 cycles.
  - `pix_rd_en`=1 for N cycles.
  - `wr_en` = `pix_rd_en` delayed 1 cycle; `wr_addr` = `pix_addr` delayed 1 cycle.
  - On exit: pulse `done`, return to IDLE. `loaded` stays 1, so the image can be re-filtered.
- **Address counter.** A single counter serves `pix_addr` and `bin_addr`. It is zeroed on every state entry and does not wrap: the terminal count forces the state transition.
- **Outputs outside their phase.** All strobes are 0; `pix_addr` and `bin_addr` hold 0.
- **Simultaneous read and apply edges in IDLE.** Read wins; the apply edge is dropped.
- **`filterType` changes mid-run.** Ignored; `mode` holds.

## Timing
- **Reset values.** All outputs 0, `stage`=IDLE, `loaded`=0, prev-registers 0. Reset applies asynchronously mid-phase: strobes drop immediately, the FSM returns to IDLE, `loaded` clears.
- **Request latency.** An edge sampled at clock edge k sets the new `stage` and the first strobe at edge k.
- **Busy duration.**
  - Load: NUM_PIXELS cycles.
  - Equalize: 2·LEVELS + 2·NUM_PIXELS + 2 cycles.
  - Negative or threshold: NUM_PIXELS+1 cycles.
- **`done` pulse.** Asserted in the first IDLE cycle, with `busy`=0.
- **`err` pulse.** Asserted in the cycle after the rejected edge.

## Test plan
- **Apply before load.** Reset release, then an apply press → `err` pulses once, `busy` stays 0, no strobes.
- **Load.** Read press → 16 cycles of `load_en` with `pix_addr` 0..15, then `done`=1 for 1 cycle, `stage`=0.
- **Equalize.** `filterType`=00, apply press → `busy` for 546 cycles.
  - `hist_clr`×256, `hist_inc`×16 (lagging `pix_rd_en` by 1), `cdf_en`×256, `wr_en`×16 with `wr_addr` 0..15.
  - `done` pulses once.
- **Negative.** `filterType`=01 → CLR/HIST/CDF skipped; `wr_en`×16 within 17 busy cycles; `mode`=01.
- **Illegal type, then busy edges.**
  - `filterType`=11 → `err` pulse, no run.
  - Then start a run and press read and apply mid-run → both ignored; the run length is unchanged.
- **Reset mid-run.** Assert `reset` during HIST → outputs 0 at once, `loaded`=0; a subsequent apply press → `err`.
